voice_scheduler: RTL
====================

VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, note-memory word-address width.
REQ-002 SHALL have parameter TICK_DIV, default 256, clk cycles per note-length unit.
REQ-003 SHALL have ports: clk  in  1  sole clock, all logic on posedge.
REQ-004 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: start  in  1  begin playback from address 0 (level sampled in IDLE).
REQ-006 SHALL have ports: stop  in  1  abort playback, silence all voices.
REQ-007 SHALL have ports: loop_en  in  1  on end marker, wrap to 0 instead of stopping.
REQ-008 SHALL have ports: mem_addr  out  ADDR_W  note word address; mem_rd  out  1  read strobe.
REQ-009 SHALL have ports: mem_data  in  32  note word; mem_valid  in  1  mem_data valid (any latency >= 1).
REQ-010 SHALL have ports: freq1..freq4  out  8 each  voice half-period in clk cycles, 0 = silent.
REQ-011 SHALL have ports: voice_active  out  4  bit n = voice n+1 sounding; playing  out  1; song_done  out  1  one-cycle pulse.

Function
REQ-012 Note word fields SHALL be: [7:0] half-period, [15:8] length in ticks, [17:16] voice (00=freq1..11=freq4), [18] any-voice flag; 32'h0 is end marker.
REQ-013 FSM states SHALL be IDLE, FETCH, WAIT, DISPATCH, DRAIN.
REQ-014 IDLE: start=1 -> FETCH with mem_addr=0; playing=0 only in IDLE.
REQ-015 FETCH: mem_rd=1 for exactly one cycle with stable mem_addr -> WAIT.
REQ-016 WAIT: mem_rd=0; on mem_valid capture mem_data -> DISPATCH; mem_valid outside WAIT SHALL be ignored.
REQ-017 DISPATCH, non-zero word with length 0: skip note, mem_addr+1 -> FETCH.
REQ-018 DISPATCH, target voice free (remaining=0): load freq and remaining next edge, mem_addr+1 -> FETCH; target busy: hold in DISPATCH with no fetch.
REQ-019 DISPATCH, end marker: loop_en=1 -> mem_addr=0, FETCH; loop_en=0 -> DRAIN.
REQ-020 Address wrap: mem_addr at 2^ADDR_W-1 SHALL wrap to 0 on increment.
REQ-021 DRAIN: wait until voice_active=0, then pulse song_done one cycle -> IDLE.
REQ-022 A free-running tick prescaler SHALL pulse every TICK_DIV cycles while playing; every busy voice decrements remaining on tick.
REQ-023 On remaining 1->0, freqN and voice_active[N] SHALL clear on that same edge.
REQ-024 Expiry and dispatch to the same voice in one cycle: dispatch SHALL wait one cycle (sees registered busy), never overwrite.
REQ-025 stop=1 in any non-IDLE state: all freqN=0, remaining=0, prescaler=0 next edge -> IDLE; no song_done pulse; stop has priority over start.
REQ-026 start while not IDLE SHALL be ignored.

Reset
REQ-027 reset SHALL drive state=IDLE, mem_addr=0, mem_rd=0, freq1..4=0, voice_active=0, playing=0, song_done=0, all remaining=0, prescaler=0 on the next edge, overriding every other input.

Configuration
REQ-028 With SCHED_AUTO_ALLOC_EN defined, a word with [18]=1 SHALL go to the lowest-numbered free voice, holding in DISPATCH if none free.
REQ-029 Without SCHED_AUTO_ALLOC_EN, bit [18] SHALL be ignored and [17:16] always selects the voice.

Structure
REQ-030 Package sched_pkg SHALL hold field bit positions, END_MARKER constant and FSM state encoding.
REQ-031 One sub-module voice_timer (load, freq, length, tick -> freq, active) SHALL be instantiated four times.

Verification
REQ-032 Reset then start; word0=32'h0000_0A20, word1=0, loop_en=0, TICK_DIV=4 -> freq1=8'h20 for 40 cycles (10 ticks, +/- one tick phase), then song_done pulse, IDLE.
REQ-033 Words voice0 len 5, voice0 len 3 -> second note held in DISPATCH, loaded only after first expires; no overlap on freq1.
REQ-034 Word with length 0 followed by valid note -> first skipped, mem_addr advances 0->1->2, freqs unaffected.
REQ-035 loop_en=1, 2-note song -> mem_addr returns to 0 after end marker, no song_done; stop mid-note -> all freq=0 next cycle, IDLE.
REQ-036 With SCHED_AUTO_ALLOC_EN, three any-voice words while voice1 busy -> loaded into freq2, freq3, freq4 in order.
REQ-037 mem_valid latency 3 cycles and reset asserted in WAIT -> IDLE next edge, late mem_valid ignored.

Source files
------------

// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared definitions for the voice scheduler
// Purpose: note-word field positions, end-marker constant and FSM state encoding.
// Ports: none (package).
package sched_pkg;

   localparam int NUM_VOICES = 4;

   // Note word layout
   localparam int HALF_LSB  = 0;
   localparam int HALF_MSB  = 7;
   localparam int LEN_LSB   = 8;
   localparam int LEN_MSB   = 15;
   localparam int VOICE_LSB = 16;
   localparam int VOICE_MSB = 17;
   localparam int ANY_BIT   = 18;

   localparam logic [31:0] END_MARKER = 32'h0000_0000;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      DISPATCH,
      DRAIN
   } state_e;

endpackage

// File: rtl/voice_timer.sv
// rtl/voice_timer.sv - one voice: holds half-period and counts down note length
// Purpose: loads a note, decrements remaining ticks, silences itself on expiry.
// Ports: clk, reset (sync, active-high), clear_i (abort), load_i, freq_i[7:0],
//        length_i[7:0], tick_i -> freq_o[7:0], active_o.
module voice_timer (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear_i,
   input  logic       load_i,
   input  logic [7:0] freq_i,
   input  logic [7:0] length_i,
   input  logic       tick_i,
   output logic [7:0] freq_o,
   output logic       active_o
);

   logic [7:0] freq_q, freq_d;
   logic [7:0] rem_q, rem_d;

   always_comb begin
      freq_d = freq_q;
      rem_d  = rem_q;
      if (clear_i) begin
         freq_d = 8'h00;
         rem_d  = 8'h00;
      end else if (load_i) begin
         freq_d = freq_i;
         rem_d  = length_i;
      end else if (tick_i && (rem_q != 8'h00)) begin
         rem_d = rem_q - 8'h01;
         // Last tick of the note: go silent on the same edge the count hits zero.
         if (rem_q == 8'h01) begin
            freq_d = 8'h00;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         freq_q <= 8'h00;
         rem_q  <= 8'h00;
      end else begin
         freq_q <= freq_d;
         rem_q  <= rem_d;
      end
   end

   assign freq_o   = freq_q;
   assign active_o = (rem_q != 8'h00);

endmodule

// File: rtl/voice_scheduler.sv
// rtl/voice_scheduler.sv - fetches note words from memory and dispatches them to four voices
// Purpose: IDLE/FETCH/WAIT/DISPATCH/DRAIN sequencer plus tick prescaler and four voice timers.
// Ports: clk, reset (sync, active-high), start, stop, loop_en,
//        mem_addr[ADDR_W-1:0], mem_rd, mem_data[31:0], mem_valid,
//        freq1..freq4[7:0], voice_active[3:0], playing, song_done.
// Build option: SCHED_AUTO_ALLOC_EN sends any-voice words to the lowest free voice.
module voice_scheduler
   import sched_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int TICK_DIV = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [31:0]       mem_data,
   input  logic              mem_valid,
   output logic [7:0]        freq1,
   output logic [7:0]        freq2,
   output logic [7:0]        freq3,
   output logic [7:0]        freq4,
   output logic [3:0]        voice_active,
   output logic              playing,
   output logic              song_done
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       word_q, word_d;
   logic              done_q, done_d;
   logic [PW-1:0]     presc_q, presc_d;

   logic       abort;
   logic       tick;
   logic [3:0] load_vec;
   logic [1:0] target;
   logic       found;
   logic [7:0] freq_w [NUM_VOICES];

   assign abort = stop && (state_q != IDLE);
   assign tick  = (presc_q == PW'(TICK_DIV - 1));

   always_comb begin
      presc_d = presc_q + PW'(1);
      if (abort || (state_q == IDLE) || tick) begin
         presc_d = '0;
      end
   end

   // Voice selection reads registered busy flags, so a voice expiring this
   // cycle is still seen as busy and gets its next note one cycle later.
   always_comb begin
      target = word_q[VOICE_MSB:VOICE_LSB];
      found  = !voice_active[target];
`ifdef SCHED_AUTO_ALLOC_EN
      if (word_q[ANY_BIT]) begin
         found = 1'b0;
         for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!voice_active[i]) begin
               target = 2'(i);
               found  = 1'b1;
            end
         end
      end
`endif
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      word_d   = word_q;
      done_d   = 1'b0;
      load_vec = 4'b0000;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  addr_d  = '0;
                  state_d = FETCH;
               end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
               if (mem_valid) begin
                  word_d  = mem_data;
                  state_d = DISPATCH;
               end
            end
            DISPATCH: begin
               if (word_q == END_MARKER) begin
                  if (loop_en) begin
                     addr_d  = '0;
                     state_d = FETCH;
                  end else begin
                     state_d = DRAIN;
                  end
               end else if (word_q[LEN_MSB:LEN_LSB] == 8'h00) begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = FETCH;
               end else if (found) begin
                  load_vec[target] = 1'b1;
                  addr_d           = addr_q + ADDR_W'(1);
                  state_d          = FETCH;
               end
            end
            DRAIN: begin
               if (voice_active == 4'b0000) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         word_q  <= '0;
         done_q  <= 1'b0;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         done_q  <= done_d;
         presc_q <= presc_d;
      end
   end

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
      voice_timer u_timer (
         .clk      (clk),
         .reset    (reset),
         .clear_i  (abort),
         .load_i   (load_vec[g]),
         .freq_i   (word_q[HALF_MSB:HALF_LSB]),
         .length_i (word_q[LEN_MSB:LEN_LSB]),
         .tick_i   (tick),
         .freq_o   (freq_w[g]),
         .active_o (voice_active[g])
      );
   end

   assign freq1     = freq_w[0];
   assign freq2     = freq_w[1];
   assign freq3     = freq_w[2];
   assign freq4     = freq_w[3];
   assign mem_addr  = addr_q;
   assign mem_rd    = (state_q == FETCH);
   assign playing   = (state_q != IDLE);
   assign song_done = done_q;

endmodule
